// File: rtl/instr_sequencer_if.sv
// Program-memory bus and issue handshake between the sequencer and its
// memory/datapath neighbours.
interface instr_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              issue_valid;
   logic              issue_ready;
   logic [7:0]        instr;
   logic [7:0]        instr_dest;
   logic [7:0]        instr_src;

   modport master (
      output mem_rd, mem_addr, issue_valid, instr, instr_dest, instr_src,
      input  mem_rdata, issue_ready
   );

   modport slave (
      input  mem_rd, mem_addr, issue_valid, instr, instr_dest, instr_src,
      output mem_rdata, issue_ready
   );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: reads variable-length instructions from a byte-wide
// synchronous program memory, assembles opcode + operands and issues them over
// a valid/ready handshake. JUMP is resolved here; HALT or running past the end
// of the program stops the run.
module instr_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int PROG_LEN   = 256,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   instr_sequencer_if.master bus,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              end_of_prog
);

   typedef enum logic [2:0] {IDLE, REQ, CAP, ISSUE, HALTED} state_t;

   localparam logic [7:0]        OP_HALT  = 8'h13;
   localparam logic [7:0]        OP_JUMP  = 8'h15;
   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
   localparam logic [31:0]       PROG_END = 32'(PROG_LEN);

   state_t            state;
   logic [1:0]        k;
   logic [1:0]        len_q;
   logic [7:0]        op_q;
   logic [7:0]        b1_q;
   logic [7:0]        cap_op;
   logic [1:0]        cap_len;
   logic [1:0]        next_k;
   logic [ADDR_W-1:0] next_pc;

   function automatic logic [1:0] op_len(input logic [7:0] op);
      if (op <= 8'h0C)      return 2'd3;
      else if (op <= 8'h15) return 2'd2;
      else                  return 2'd1;
   endfunction

   function automatic logic in_prog(input logic [ADDR_W-1:0] a);
      return 32'(a) < PROG_END;
   endfunction

   // Opcode/length of the instruction being captured, and the PC after issue.
   always_comb begin
      cap_op  = (k == 2'd0) ? bus.mem_rdata : op_q;
      cap_len = (k == 2'd0) ? op_len(bus.mem_rdata) : len_q;
      next_k  = k + 2'd1;
      next_pc = (bus.instr == OP_JUMP) ? ADDR_W'(bus.instr_src)
                                       : pc + ADDR_W'(len_q);
   end

   // Sequencer FSM. The end-of-program test is made when entering REQ, so
   // mem_rd being low in REQ means "no fetch, stop the run".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         pc              <= START_PC;
         k               <= '0;
         len_q           <= '0;
         op_q            <= '0;
         b1_q            <= '0;
         bus.mem_rd      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.issue_valid <= 1'b0;
         bus.instr       <= '0;
         bus.instr_dest  <= '0;
         bus.instr_src   <= '0;
         busy            <= 1'b0;
         halted          <= 1'b0;
         end_of_prog     <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  pc           <= START_PC;
                  k            <= '0;
                  end_of_prog  <= 1'b0;
                  busy         <= 1'b1;
                  halted       <= 1'b0;
                  bus.mem_rd   <= in_prog(START_PC);
                  bus.mem_addr <= START_PC;
                  state        <= REQ;
               end
            end
            REQ: begin
               if (!bus.mem_rd) begin
                  end_of_prog <= 1'b1;
                  busy        <= 1'b0;
                  halted      <= 1'b1;
                  state       <= HALTED;
               end else begin
                  bus.mem_rd <= 1'b0;
                  state      <= CAP;
               end
            end
            CAP: begin
               op_q  <= cap_op;
               len_q <= cap_len;
               if (k == 2'd1) b1_q <= bus.mem_rdata;
               if (next_k < cap_len) begin
                  k            <= next_k;
                  bus.mem_rd   <= 1'b1;
                  bus.mem_addr <= pc + ADDR_W'(next_k);
                  state        <= REQ;
               end else begin
                  bus.instr <= cap_op;
                  case (cap_len)
                     2'd3: begin
                        bus.instr_dest <= b1_q;
                        bus.instr_src  <= bus.mem_rdata;
                     end
                     2'd2: begin
                        if (cap_op == OP_JUMP) begin
                           bus.instr_dest <= '0;
                           bus.instr_src  <= bus.mem_rdata;
                        end else begin
                           bus.instr_dest <= bus.mem_rdata;
                           bus.instr_src  <= '0;
                        end
                     end
                     default: begin
                        bus.instr_dest <= '0;
                        bus.instr_src  <= '0;
                     end
                  endcase
                  bus.issue_valid <= 1'b1;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.issue_ready) begin
                  bus.issue_valid <= 1'b0;
                  k               <= '0;
                  if (bus.instr == OP_HALT) begin
                     busy   <= 1'b0;
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc           <= next_pc;
                     bus.mem_rd   <= in_prog(next_pc);
                     bus.mem_addr <= next_pc;
                     state        <= REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: two instances (full 256-byte program and
// a 4-byte program), behavioural synchronous program memories, issue log.
module tb_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, start2;
   logic [7:0] pc, pc2;
   logic       busy, halted, eop, busy2, halted2, eop2;

   instr_sequencer_if #(.ADDR_W(8)) bus ();
   instr_sequencer_if #(.ADDR_W(8)) bus2 ();

   instr_sequencer #(.ADDR_W(8), .PROG_LEN(256), .START_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .pc(pc), .busy(busy), .halted(halted), .end_of_prog(eop)
   );

   instr_sequencer #(.ADDR_W(8), .PROG_LEN(4), .START_ADDR(0)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .bus(bus2),
      .pc(pc2), .busy(busy2), .halted(halted2), .end_of_prog(eop2)
   );

   logic [7:0]  mem  [256];
   logic [7:0]  mem2 [256];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          bad_fetch = 0;
   int          cnt;

   // Synchronous program memories: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.mem_rd)  bus.mem_rdata  <= mem[bus.mem_addr];
      if (bus2.mem_rd) bus2.mem_rdata <= mem2[bus2.mem_addr];
   end

   // Issue log {pc, instr, dest, src} and fetch watch for addresses 2/3.
   always @(negedge clk) begin
      if (bus.issue_valid && bus.issue_ready)
         q1.push_back({pc, bus.instr, bus.instr_dest, bus.instr_src});
      if (bus2.issue_valid && bus2.issue_ready)
         q2.push_back({pc2, bus2.instr, bus2.instr_dest, bus2.instr_src});
      if (bus.mem_rd && (bus.mem_addr == 8'h02 || bus.mem_addr == 8'h03))
         bad_fetch++;
   end

   // A read is always followed by a capture cycle, never a back-to-back read.
   assert property (@(posedge clk) disable iff (!reset) bus.mem_rd |=> !bus.mem_rd);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 8'h00;
         mem2[i] = 8'h00;
      end
   endtask

   task automatic load_add_halt();
      clear_mem();
      mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h03; mem[3] = 8'h13; mem[4] = 8'h00;
   endtask

   task automatic pulse_start(input bit second);
      @(posedge clk); #1;
      if (second) start2 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_halt(input bit second);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (second ? halted2 : halted) break;
      end
      check("halt_wait", {31'd0, (second ? halted2 : halted)}, 32'd1);
   endtask

   task automatic measure_latency();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.issue_valid) break;
         cnt++;
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; start2 = 1'b0;
      bus.issue_ready = 1'b1; bus2.issue_ready = 1'b1;
      clear_mem();
      repeat (2) @(posedge clk);
      #1;
      check("rst_outs", {busy, halted, eop, bus.mem_rd, bus.issue_valid, 3'd0,
                         bus.instr, bus.instr_dest, bus.instr_src}, 32'd0);
      check("rst_pc", {24'd0, pc}, 32'd0);
      check("rst_outs2", {27'd0, busy2, halted2, eop2, bus2.mem_rd, bus2.issue_valid}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      // 1: ADD then HALT
      load_add_halt();
      q1.delete();
      pulse_start(1'b0);
      measure_latency();
      check("t1_lat3", cnt, 32'd6);
      wait_halt(1'b0);
      check("t1_count", q1.size(), 32'd2);
      check("t1_i0", q1[0], 32'h00_00_05_03);
      check("t1_i1", q1[1], 32'h03_13_00_00);
      check("t1_state", {24'd0, pc, 5'd0, busy, halted, eop}, {24'd0, 8'h03, 5'd0, 3'b010});

      // 2: JUMP over two bytes
      clear_mem();
      mem[0] = 8'h15; mem[1] = 8'h04; mem[2] = 8'hFF; mem[3] = 8'hFF;
      mem[4] = 8'h0D; mem[5] = 8'h07; mem[6] = 8'h13; mem[7] = 8'h00;
      q1.delete();
      bad_fetch = 0;
      pulse_start(1'b0);
      measure_latency();
      check("t2_lat2", cnt, 32'd4);
      wait_halt(1'b0);
      check("t2_count", q1.size(), 32'd3);
      check("t2_i0", q1[0], 32'h00_15_00_04);
      check("t2_i1", q1[1], 32'h04_0D_07_00);
      check("t2_i2", q1[2], 32'h06_13_00_00);
      check("t2_nofetch", bad_fetch, 32'd0);
      check("t2_pc", {24'd0, pc}, 32'h06);

      // 3: back-pressure on ADD
      load_add_halt();
      q1.delete();
      bus.issue_ready = 1'b0;
      pulse_start(1'b0);
      measure_latency();
      check("t3_valid", {31'd0, bus.issue_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_v", {31'd0, bus.issue_valid}, 32'd1);
         check("t3_hold_f", {8'd0, bus.instr, bus.instr_dest, bus.instr_src}, 32'h00_00_05_03);
      end
      check("t3_no_rd", {31'd0, bus.mem_rd}, 32'd0);
      @(posedge clk); #1 bus.issue_ready = 1'b1;
      @(negedge clk);
      check("t3_pre_acc", {31'd0, bus.issue_valid}, 32'd1);
      @(negedge clk);
      check("t3_advance", {22'd0, bus.issue_valid, bus.mem_rd, bus.mem_addr}, {22'd0, 2'b01, 8'h03});
      wait_halt(1'b0);
      check("t3_count", q1.size(), 32'd2);

      // 5: reset during capture of the second operand
      load_add_halt();
      q1.delete();
      pulse_start(1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.mem_rd && bus.mem_addr == 8'h02) break;
      end
      check("t5_req2", {31'd0, bus.mem_rd}, 32'd1);
      @(posedge clk); #1 reset = 1'b0;
      #1;
      check("t5_rst_outs", {busy, halted, eop, bus.mem_rd, bus.issue_valid, 3'd0,
                            bus.instr, bus.instr_dest, bus.instr_src}, 32'd0);
      check("t5_rst_pc", {24'd0, pc}, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      q1.delete();
      pulse_start(1'b0);
      wait_halt(1'b0);
      check("t5_rerun_cnt", q1.size(), 32'd2);
      check("t5_rerun_i0", q1[0], 32'h00_00_05_03);

      // 6: operand fetch wraps from FF to 00
      clear_mem();
      mem[0] = 8'h15; mem[1] = 8'hFF; mem[2] = 8'h13; mem[3] = 8'h00; mem[255] = 8'h10;
      q1.delete();
      pulse_start(1'b0);
      wait_halt(1'b0);
      check("t6_count", q1.size(), 32'd4);
      check("t6_jump", q1[0], 32'h00_15_00_FF);
      check("t6_wrap", q1[1], 32'hFF_10_15_00);
      check("t6_nextpc", q1[2], 32'h01_FF_00_00);
      check("t6_halt", q1[3], 32'h02_13_00_00);

      // 4: run ends at PROG_LEN
      clear_mem();
      mem2[0] = 8'h0C; mem2[1] = 8'h01; mem2[2] = 8'h02; mem2[3] = 8'hFE;
      q2.delete();
      pulse_start(1'b1);
      wait_halt(1'b1);
      check("t4_count", q2.size(), 32'd2);
      check("t4_i0", q2[0], 32'h00_0C_01_02);
      check("t4_i1", q2[1], 32'h03_FE_00_00);
      check("t4_state", {24'd0, pc2, 5'd0, busy2, halted2, eop2}, {24'd0, 8'h04, 5'd0, 3'b011});
      pulse_start(1'b1);
      check("t4_restart", {29'd0, busy2, halted2, eop2}, {29'd0, 3'b100});
      wait_halt(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
